// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman/LZ77 bit packer family: FSM state
// encodings, default widths and the parameter legality check.
package huff_pkg;

    // FSM states, kept as plain constants so older tools and checkers bind cleanly
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN   = 2'd0;  // accepting codes
    localparam state_t ST_FLUSH = 2'd1;  // draining buffered bits, no input
    localparam state_t ST_END   = 2'd2;  // one-cycle clear, then back to RUN

    localparam int DEF_OUT_W = 64;
    localparam int BYTES_W   = $clog2(DEF_OUT_W / 8) + 1;

    // The accumulator must hold a full output word plus one worst-case code,
    // otherwise a stalled output could block the input forever.
    function automatic bit widths_legal(input int in_w, input int out_w, input int acc_w);
        return (acc_w >= out_w + in_w) && (out_w > 0) && (out_w % 8 == 0) && (in_w > 0);
    endfunction

endpackage

// File: rtl/huff_bit_packer_merge.sv
// bit_merge_unit: masks a code to its length and ORs it into an accumulator
// at an arbitrary bit offset. Purely combinational.
module bit_merge_unit
    import huff_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int LEN_W = 6,
    parameter int ACC_W = 128,
    parameter int OFF_W = $clog2(ACC_W + 1)
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [IN_W-1:0]  code,
    input  logic [LEN_W-1:0] len,     // already clamped to 0..IN_W
    input  logic [OFF_W-1:0] offset,
    output logic [ACC_W-1:0] acc_out
);

    logic [IN_W:0]    one_hot;
    logic [IN_W-1:0]  mask;
    logic [ACC_W-1:0] code_ext;

    // Build (1<<len)-1 one bit wider so len==IN_W yields all ones, then merge
    always_comb begin
        one_hot  = (IN_W + 1)'(1) << len;
        mask     = IN_W'(one_hot - (IN_W + 1)'(1));
        code_ext = ACC_W'(code & mask);
        acc_out  = acc_in | (code_ext << offset);
    end

endmodule

// File: rtl/huff_bit_packer.sv
// huff_bit_packer: packs variable-length codes LSB-first into an accumulator
// and emits fixed-width words; on end-of-stream flushes a zero-padded final
// word with its byte count.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. valid never waits for ready; once out_valid is high the word
// (out_data/out_bytes/out_last) holds until it is taken, because new codes
// only land at bit positions >= fill >= OUT_W.
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int LEN_W = 6,
    parameter int OUT_W = DEF_OUT_W,
    parameter int ACC_W = 128,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    input  logic [LEN_W-1:0]              in_len,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(OUT_W/8):0]      out_bytes,
    output logic                          out_last,
    output logic [CNT_W-1:0]              bit_count,
    output logic [1:0]                    dbg_state,
    output logic [$clog2(ACC_W+1)-1:0]    dbg_fill
);

    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int BYTE_W = $clog2(OUT_W / 8) + 1;

    if (!widths_legal(IN_W, OUT_W, ACC_W)) begin : g_bad_widths
        $error("huff_bit_packer: ACC_W must be >= OUT_W + IN_W and OUT_W a multiple of 8");
    end

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [FILL_W-1:0]  fill;

    logic [LEN_W-1:0]   len_c;
    logic               accept;
    logic               deliver;
    logic               final_word;
    logic [FILL_W-1:0]  fill_dec;
    logic [FILL_W-1:0]  merge_off;
    logic [ACC_W-1:0]   acc_base;
    logic [ACC_W-1:0]   acc_merged;
    logic [FILL_W-1:0]  fill_nxt;

    // Handshake decode and next-fill arithmetic
    always_comb begin
        len_c      = (in_len > LEN_W'(IN_W)) ? LEN_W'(IN_W) : in_len;
        in_ready   = reset && (state == ST_RUN) && (fill <= FILL_W'(ACC_W - IN_W));
        out_valid  = reset && ((fill >= FILL_W'(OUT_W)) || (state == ST_FLUSH));
        accept     = in_valid && in_ready;
        deliver    = out_valid && out_ready;
        final_word = (state == ST_FLUSH) && (fill <= FILL_W'(OUT_W));
        fill_dec   = (fill >= FILL_W'(OUT_W)) ? fill - FILL_W'(OUT_W) : '0;
        merge_off  = deliver ? fill_dec : fill;
        acc_base   = deliver ? (acc >> OUT_W) : acc;
        fill_nxt   = (deliver ? fill_dec : fill) + (accept ? FILL_W'(len_c) : '0);
    end

    bit_merge_unit #(
        .IN_W  (IN_W),
        .LEN_W (LEN_W),
        .ACC_W (ACC_W),
        .OFF_W (FILL_W)
    ) u_merge (
        .acc_in  (acc_base),
        .code    (in_data),
        .len     (len_c),
        .offset  (merge_off),
        .acc_out (acc_merged)
    );

    // Output word view: full words in RUN and early FLUSH, byte-counted final word
    always_comb begin
        out_data  = acc[OUT_W-1:0];
        out_last  = reset && final_word;
        if (!reset) begin
            out_bytes = '0;
        end else if (final_word) begin
            out_bytes = BYTE_W'(({1'b0, fill} + (FILL_W + 1)'(7)) >> 3);
        end else begin
            out_bytes = BYTE_W'(OUT_W / 8);
        end
        dbg_state = state;
        dbg_fill  = fill;
    end

    // Accumulator, fill level, stream bit counter and FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            acc       <= '0;
            fill      <= '0;
            bit_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    acc  <= accept ? acc_merged : acc_base;
                    fill <= fill_nxt;
                    if (accept) begin
                        bit_count <= bit_count + CNT_W'(len_c);
                        if (in_last) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    acc  <= acc_base;
                    fill <= fill_nxt;
                    if (deliver && final_word) state <= ST_END;
                end
                default: begin
                    acc       <= '0;
                    fill      <= '0;
                    bit_count <= '0;
                    state     <= ST_RUN;
                end
            endcase
        end
    end

endmodule
